reg_pipe: RTL
=============

// Module: reg_pipe
//
// PURPOSE
// - Parametrised elastic pipeline register. Chains DEPTH register stages with a
//   valid/ready handshake per stage.
// - Successor to the plain always-load pipeline register. Adds backpressure,
//   bubble collapsing, synchronous flush and an occupancy count.
// - Used between arithmetic units (adders, multipliers) to retime long
//   datapaths without losing throughput under stalls.
//
// PARAMETERS
// - width   8  data word width in bits, >= 1
// - depth   2  number of register stages, >= 1; latency in cycles with no stall
//
// PORTS
// - CLK        in   1                   clock, rising edge
// - RST        in   1                   reset, asynchronous, active-low
// - CLR        in   1                   synchronous flush, active-high
// - IN_VALID   in   1                   upstream word valid
// - IN_READY   out  1                   pipe accepts a word this cycle
// - D          in   width               upstream data
// - OUT_VALID  out  1                   word available at output
// - OUT_READY  in   1                   downstream accepts output word
// - Q          out  width               output data (last stage register)
// - FILL       out  $clog2(depth+1)     number of occupied stages
//
// BEHAVIOUR
// - Transfers:
//   - A transfer occurs on an edge where valid=1 and ready=1 at that interface.
//   - D is sampled only on an input transfer.
//   - Q/OUT_VALID are held stable while OUT_VALID=1 and OUT_READY=0.
// - Stage state: stage i (0 = input side, depth-1 = output side) holds v[i]
//   and data[i].
// - Ready chain, combinational:
//   - rdy[depth-1] = !v[depth-1] | OUT_READY
//   - rdy[i] = !v[i] | rdy[i+1]
//   - IN_READY = rdy[0] & !CLR
//   - The OUT_READY -> IN_READY combinational path is intended; no skid buffer.
// - Stage update, on each rising edge where stage i is ready (rdy[i]=1):
//   - v[i] <= v[i-1]; data[i] loads data[i-1] only if v[i-1]=1.
//   - Stage 0 takes IN_VALID / D instead of stage i-1.
//   - A not-ready stage holds v[i] and data[i].
//   - Bubbles collapse: an empty stage always accepts, even when downstream
//     is stalled.
// - Latency and throughput:
//   - depth cycles from input transfer to OUT_VALID with OUT_READY held 1.
//   - Throughput 1 word/cycle.
//   - Capacity depth words.
// - Outputs:
//   - OUT_VALID = v[depth-1] & !CLR
//   - Q = data[depth-1]
//   - FILL = popcount(v), registered-state derived; no combinational input
//     dependence.
// - CLR:
//   - On the edge with CLR=1 all v[i] <= 0. Data registers keep their values.
//   - No input or output transfer takes place in a CLR cycle: IN_READY=0 and
//     OUT_VALID=0 during CLR.
//   - CLR has priority over all transfers.
// - Reset (RST=0, at any time, including mid-stream):
//   - all v[i]=0, all data[i]='0 immediately (asynchronous).
//   - Hence OUT_VALID=0, Q='0, FILL=0. IN_READY=1 while CLR=0.
//   - Data in flight is discarded; first accepted word after release appears
//     after depth cycles.
// - Boundaries:
//   - Full (FILL=depth, OUT_READY=0): IN_READY=0, contents frozen.
//   - Full with OUT_READY=1: simultaneous in and out transfer, FILL unchanged.
//   - Empty: OUT_VALID=0; Q shows stale data (or '0 after reset) and must not
//     be consumed.
//   - depth=1: single stage; IN_READY = !v[0] | OUT_READY.
//
// STRUCTURE
// - Shared package arith_pkg: no new typedefs required. FILL width is computed
//   locally via $clog2(depth+1).
// - Sub-module reg_pipe_stage: one valid+data stage with ports
//   CLK, RST, CLR, in_valid, in_data, out_ready -> in_ready, out_valid,
//   out_data.
// - reg_pipe instantiates depth of these in a generate loop and sums valids
//   for FILL.
//
// TESTING (width=8, depth=3 unless stated)
// - Streaming: IN_VALID=1, D=1,2,3,... every cycle, OUT_READY=1 ->
//   OUT_VALID rises 3 cycles after first accept; Q=1,2,3,... one per cycle;
//   IN_READY stays 1.
// - Stall/full: feed 0xA1,0xA2,0xA3,0xA4 with OUT_READY=0 ->
//   0xA1..0xA3 accepted, FILL=3, IN_READY=0, 0xA4 held upstream.
//   Raise OUT_READY -> Q=0xA1,0xA2,0xA3,0xA4 in order, no loss or duplication.
// - Bubble collapse: accept 0x10, idle 2 cycles, accept 0x20 with OUT_READY=0
//   -> both compact to stages 2 and 1; FILL=2; IN_READY=1.
// - Flush: FILL=2, pulse CLR for 1 cycle with IN_VALID=1, OUT_READY=1 ->
//   during CLR IN_READY=0 and OUT_VALID=0; next cycle FILL=0; no word output,
//   no word accepted.
// - Async reset mid-stream: assert RST=0 between clock edges with FILL=3 ->
//   OUT_VALID=0, Q=0x00, FILL=0 before next edge. After release, D=0x5A ->
//   Q=0x5A 3 cycles later.
// - Random: depth in {1,2,5}, random IN_VALID/OUT_READY, scoreboard check of
//   order, count, and FILL each cycle.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared constants for the arithmetic datapath blocks.
// Pipeline registers take their default geometry from here.
package arith_pkg;

    localparam int unsigned PipeWidthDefault = 8;
    localparam int unsigned PipeDepthDefault = 2;

endpackage

// File: rtl/reg_pipe_stage.sv
// One elastic pipeline stage: a valid bit plus a data word with valid/ready handshake.
// The stage accepts whenever it is empty or its content leaves this cycle.
module reg_pipe_stage
    import arith_pkg::*;
#(
    parameter int unsigned width = PipeWidthDefault
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLR,
    input  logic             in_valid,
    input  logic [width-1:0] in_data,
    input  logic             out_ready,
    output logic             in_ready,
    output logic             out_valid,
    output logic [width-1:0] out_data
);

    logic             v_q, v_d;
    logic [width-1:0] data_q, data_d;

    assign in_ready  = ~v_q | out_ready;
    assign out_valid = v_q;
    assign out_data  = data_q;

    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        // Flush drops the valid bit only; the data word is left as is.
        if (CLR) begin
            v_d = 1'b0;
        end else if (in_ready) begin
            v_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            v_q    <= 1'b0;
            data_q <= '0;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/reg_pipe.sv
// Elastic pipeline register: depth chained stages with backpressure, bubble collapsing,
// synchronous flush and an occupancy count.
module reg_pipe
    import arith_pkg::*;
#(
    parameter int unsigned width = PipeWidthDefault,
    parameter int unsigned depth = PipeDepthDefault
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         CLR,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    input  logic [width-1:0]             D,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic [width-1:0]             Q,
    output logic [$clog2(depth+1)-1:0]   FILL
);

    localparam int unsigned FillW = $clog2(depth + 1);

    // Index i is the input of stage i; index depth is the pipe output.
    logic [depth:0]   valid_chain;
    logic [depth:0]   ready_chain;
    logic [width-1:0] data_chain [depth+1];
    logic [FillW-1:0] fill_sum;

    assign valid_chain[0]     = IN_VALID;
    assign data_chain[0]      = D;
    assign ready_chain[depth] = OUT_READY;

    for (genvar i = 0; i < int'(depth); i++) begin : g_stage
        reg_pipe_stage #(
            .width (width)
        ) u_stage (
            .CLK       (CLK),
            .RST       (RST),
            .CLR       (CLR),
            .in_valid  (valid_chain[i]),
            .in_data   (data_chain[i]),
            .out_ready (ready_chain[i+1]),
            .in_ready  (ready_chain[i]),
            .out_valid (valid_chain[i+1]),
            .out_data  (data_chain[i+1])
        );
    end

    // Occupancy depends on stage valids only, never on the current inputs.
    always_comb begin
        fill_sum = '0;
        for (int i = 0; i < int'(depth); i++) begin
            fill_sum = fill_sum + FillW'(valid_chain[i+1]);
        end
    end

    assign IN_READY  = ready_chain[0] & ~CLR;
    assign OUT_VALID = valid_chain[depth] & ~CLR;
    assign Q         = data_chain[depth];
    assign FILL      = fill_sum;

endmodule
